operand_fetch_stage: RTL and testbench

//  ID->EX operand stage. Drives register_file read addresses from the decoded instruction.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/fwd_mux.sv | 40 ++++
 rtl/operand_fetch_stage.sv | 145 ++++++++++++++
 tb/tb_operand_fetch_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS-style pipeline slice.
package mips_pkg;

  localparam int BUS_WIDTH = 16;
  localparam int DEPTH     = 8;
  localparam int ADDR_SIZE = $clog2(DEPTH);
  localparam int CTRL_W    = 8;

  // Operand source, ordered from lowest to highest forwarding priority.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } fwd_sel_t;

  // A later stage produces the value of src when it writes that register.
  function automatic logic wr_match(input logic                 en,
                                    input logic [ADDR_SIZE-1:0] wr_addr,
                                    input logic [ADDR_SIZE-1:0] src);
    return en && (wr_addr == src);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding select: EX > MEM > WB > register file.
// Purely combinational; one instance per source operand.
module fwd_mux
  import mips_pkg::*;
(
  input  logic [ADDR_SIZE-1:0] src,
  input  logic [BUS_WIDTH-1:0] rf_data,
  input  logic                 ex_wr_en,
  input  logic [ADDR_SIZE-1:0] ex_wr_addr,
  input  logic [BUS_WIDTH-1:0] ex_result,
  input  logic                 mem_wr_en,
  input  logic [ADDR_SIZE-1:0] mem_wr_addr,
  input  logic [BUS_WIDTH-1:0] mem_result,
  input  logic                 wb_wr_en,
  input  logic [ADDR_SIZE-1:0] wb_wr_addr,
  input  logic [BUS_WIDTH-1:0] wb_wr_data,
  output logic [BUS_WIDTH-1:0] data
);

  fwd_sel_t sel;

  // Pick the youngest in-flight producer of src, falling back to the RF.
  always_comb begin
    sel = FWD_RF;
    if (wr_match(ex_wr_en, ex_wr_addr, src))        sel = FWD_EX;
    else if (wr_match(mem_wr_en, mem_wr_addr, src)) sel = FWD_MEM;
    else if (wr_match(wb_wr_en, wb_wr_addr, src))   sel = FWD_WB;
  end

  // Steer the selected value onto the operand bus.
  always_comb begin
    case (sel)
      FWD_EX:  data = ex_result;
      FWD_MEM: data = mem_result;
      FWD_WB:  data = wb_wr_data;
      default: data = rf_data;
    endcase
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// ID->EX operand stage: RF read addressing, forwarding, load-use / WB
// hazard stalls and the ID/EX pipeline register.
// Build option: RF_WB_BYPASS_EN enables forwarding of the WB write data;
// without it a WB match on a used source stalls one cycle instead.
module operand_fetch_stage
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [ADDR_SIZE-1:0] id_rs,
  input  logic [ADDR_SIZE-1:0] id_rt,
  input  logic                 id_rs_used,
  input  logic                 id_rt_used,
  input  logic [ADDR_SIZE-1:0] id_rd,
  input  logic [BUS_WIDTH-1:0] id_imm,
  input  logic [CTRL_W-1:0]    id_ctrl,
  output logic                 id_stall,
  output logic [ADDR_SIZE-1:0] rf_rd_addr_1,
  output logic [ADDR_SIZE-1:0] rf_rd_addr_2,
  input  logic [BUS_WIDTH-1:0] rf_rd_data_1,
  input  logic [BUS_WIDTH-1:0] rf_rd_data_2,
  input  logic                 ex_wr_en,
  input  logic [ADDR_SIZE-1:0] ex_wr_addr,
  input  logic [BUS_WIDTH-1:0] ex_result,
  input  logic                 ex_is_load,
  input  logic                 mem_wr_en,
  input  logic [ADDR_SIZE-1:0] mem_wr_addr,
  input  logic [BUS_WIDTH-1:0] mem_result,
  input  logic                 wb_wr_en,
  input  logic [ADDR_SIZE-1:0] wb_wr_addr,
  input  logic [BUS_WIDTH-1:0] wb_wr_data,
  input  logic                 ex_ready,
  input  logic                 flush,
  output logic                 ex_valid,
  output logic [BUS_WIDTH-1:0] ex_op_a,
  output logic [BUS_WIDTH-1:0] ex_op_b,
  output logic [BUS_WIDTH-1:0] ex_imm,
  output logic [ADDR_SIZE-1:0] ex_rd,
  output logic [CTRL_W-1:0]    ex_ctrl
);

  logic                 wb_fwd_en;
  logic [BUS_WIDTH-1:0] op_a_fwd, op_b_fwd;
  logic                 load_use, wb_hazard, hazard;

  logic                 ex_valid_q, ex_valid_d;
  logic [BUS_WIDTH-1:0] ex_op_a_q,  ex_op_a_d;
  logic [BUS_WIDTH-1:0] ex_op_b_q,  ex_op_b_d;
  logic [BUS_WIDTH-1:0] ex_imm_q,   ex_imm_d;
  logic [ADDR_SIZE-1:0] ex_rd_q,    ex_rd_d;
  logic [CTRL_W-1:0]    ex_ctrl_q,  ex_ctrl_d;

  assign rf_rd_addr_1 = id_rs;
  assign rf_rd_addr_2 = id_rt;

`ifdef RF_WB_BYPASS_EN
  assign wb_fwd_en = wb_wr_en;
`else
  // The RF only reflects a WB write after the edge, so WB is never a source.
  assign wb_fwd_en = 1'b0;
`endif

  fwd_mux u_fwd_rs (
    .src(id_rs), .rf_data(rf_rd_data_1),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_result(ex_result),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_result(mem_result),
    .wb_wr_en(wb_fwd_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .data(op_a_fwd)
  );

  fwd_mux u_fwd_rt (
    .src(id_rt), .rf_data(rf_rd_data_2),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_result(ex_result),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_result(mem_result),
    .wb_wr_en(wb_fwd_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .data(op_b_fwd)
  );

  // Hazard detection and the upstream hold request.
  always_comb begin
    load_use = id_valid && ex_wr_en && ex_is_load &&
               ((id_rs_used && (id_rs == ex_wr_addr)) ||
                (id_rt_used && (id_rt == ex_wr_addr)));
`ifdef RF_WB_BYPASS_EN
    wb_hazard = 1'b0;
`else
    wb_hazard = id_valid && wb_wr_en &&
                ((id_rs_used && (id_rs == wb_wr_addr)) ||
                 (id_rt_used && (id_rt == wb_wr_addr)));
`endif
    hazard   = load_use || wb_hazard;
    // Backpressure always holds; a flushed instruction never needs to wait.
    id_stall = !ex_ready || (!flush && hazard);
  end

  // ID/EX next state: hold on backpressure, bubble on flush/hazard, else capture.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_a_d  = ex_op_a_q;
    ex_op_b_d  = ex_op_b_q;
    ex_imm_d   = ex_imm_q;
    ex_rd_d    = ex_rd_q;
    ex_ctrl_d  = ex_ctrl_q;
    if (ex_ready) begin
      if (flush || hazard) begin
        ex_valid_d = 1'b0;
      end else begin
        ex_valid_d = id_valid;
        ex_op_a_d  = op_a_fwd;
        ex_op_b_d  = op_b_fwd;
        ex_imm_d   = id_imm;
        ex_rd_d    = id_rd;
        ex_ctrl_d  = id_ctrl;
      end
    end
  end

  // ID/EX pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_op_a_q  <= '0;
      ex_op_b_q  <= '0;
      ex_imm_q   <= '0;
      ex_rd_q    <= '0;
      ex_ctrl_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_a_q  <= ex_op_a_d;
      ex_op_b_q  <= ex_op_b_d;
      ex_imm_q   <= ex_imm_d;
      ex_rd_q    <= ex_rd_d;
      ex_ctrl_q  <= ex_ctrl_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_op_a  = ex_op_a_q;
  assign ex_op_b  = ex_op_b_q;
  assign ex_imm   = ex_imm_q;
  assign ex_rd    = ex_rd_q;
  assign ex_ctrl  = ex_ctrl_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: vector table plus hand sequences for
// backpressure/flush/reset; registered results go through a scoreboard queue.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs_used, id_rt_used;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm;
  logic [7:0]  id_ctrl;
  logic        id_stall;
  logic [2:0]  rf_rd_addr_1, rf_rd_addr_2;
  logic [15:0] rf_rd_data_1, rf_rd_data_2;
  logic        ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
  logic [2:0]  ex_wr_addr, mem_wr_addr, wb_wr_addr;
  logic [15:0] ex_result, mem_result, wb_wr_data;
  logic        ex_ready, flush;
  logic        ex_valid;
  logic [15:0] ex_op_a, ex_op_b, ex_imm;
  logic [2:0]  ex_rd;
  logic [7:0]  ex_ctrl;

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_stall(id_stall),
    .rf_rd_addr_1(rf_rd_addr_1), .rf_rd_addr_2(rf_rd_addr_2),
    .rf_rd_data_1(rf_rd_data_1), .rf_rd_data_2(rf_rd_data_2),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_result(ex_result), .ex_is_load(ex_is_load),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_result(mem_result),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .ex_ready(ex_ready), .flush(flush),
    .ex_valid(ex_valid), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
  );

  typedef struct {
    logic        v;
    logic [2:0]  rs, rt;
    logic        rs_u, rt_u;
    logic [2:0]  rd;
    logic [15:0] imm;
    logic [7:0]  ctrl;
    logic [15:0] rf1, rf2;
  } id_t;

  typedef struct {
    logic        en;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        load;
  } fw_t;

  typedef struct {
    logic        s;
    logic        v;
    logic [15:0] a, b, imm;
    logic [2:0]  rd;
    logic [7:0]  ctrl;
  } exp_t;

  typedef struct {
    logic rst, ready, flush;
    id_t  id;
    fw_t  ex, mem, wb;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    rst          = v.rst;
    ex_ready     = v.ready;
    flush        = v.flush;
    id_valid     = v.id.v;
    id_rs        = v.id.rs;
    id_rt        = v.id.rt;
    id_rs_used   = v.id.rs_u;
    id_rt_used   = v.id.rt_u;
    id_rd        = v.id.rd;
    id_imm       = v.id.imm;
    id_ctrl      = v.id.ctrl;
    rf_rd_data_1 = v.id.rf1;
    rf_rd_data_2 = v.id.rf2;
    ex_wr_en     = v.ex.en;
    ex_wr_addr   = v.ex.addr;
    ex_result    = v.ex.data;
    ex_is_load   = v.ex.load;
    mem_wr_en    = v.mem.en;
    mem_wr_addr  = v.mem.addr;
    mem_result   = v.mem.data;
    wb_wr_en     = v.wb.en;
    wb_wr_addr   = v.wb.addr;
    wb_wr_data   = v.wb.data;
    #1;
    chk({tag, " id_stall"}, 32'(id_stall), 32'(v.e.s));
    chk({tag, " rf_rd_addr_1"}, 32'(rf_rd_addr_1), 32'(v.id.rs));
    chk({tag, " rf_rd_addr_2"}, 32'(rf_rd_addr_2), 32'(v.id.rt));
    sb.push_back(v.e);
    n_vec++;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      chk({tag, " ex_valid"}, 32'(ex_valid), 32'(e.v));
      chk({tag, " ex_op_a"},  32'(ex_op_a),  32'(e.a));
      chk({tag, " ex_op_b"},  32'(ex_op_b),  32'(e.b));
      chk({tag, " ex_imm"},   32'(ex_imm),   32'(e.imm));
      chk({tag, " ex_rd"},    32'(ex_rd),    32'(e.rd));
      chk({tag, " ex_ctrl"},  32'(ex_ctrl),  32'(e.ctrl));
    end
  endtask

  vec_t tbl[12];
  vec_t h;
  fw_t  nf;
  id_t  id0, id_hold, id_new;
  exp_t e_frozen;

  initial begin
    nf  = '{1'b0, 3'd0, 16'h0000, 1'b0};
    id0 = '{1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 16'h0000, 16'h0000};

    // Reset, then idle after release: everything stays zero.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, id0, nf, nf, nf, '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 8'h00}};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, id0, nf, nf, nf, '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 8'h00}};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, id0, nf, nf, nf, '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 8'h00}};
    // Plain RF read: ADD r4 = r3 + r3.
    tbl[3]  = '{1'b0, 1'b1, 1'b0,
                '{1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 3'd4, 16'h0010, 8'h11, 16'h1234, 16'h1234}, nf, nf, nf,
                '{1'b0, 1'b1, 16'h1234, 16'h1234, 16'h0010, 3'd4, 8'h11}};
    // EX and MEM both write r2: EX wins.
    tbl[4]  = '{1'b0, 1'b1, 1'b0,
                '{1'b1, 3'd2, 3'd6, 1'b1, 1'b1, 3'd7, 16'hFFFE, 8'h22, 16'h0002, 16'h0006},
                '{1'b1, 3'd2, 16'h00AA, 1'b0}, '{1'b1, 3'd2, 16'h00BB, 1'b0}, nf,
                '{1'b0, 1'b1, 16'h00AA, 16'h0006, 16'hFFFE, 3'd7, 8'h22}};
    // MEM forwards rt only; EX writes an unrelated register.
    tbl[5]  = '{1'b0, 1'b1, 1'b0,
                '{1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd2, 16'h0003, 8'h66, 16'h0101, 16'h0202},
                '{1'b1, 3'd5, 16'hDEAD, 1'b0}, '{1'b1, 3'd2, 16'h0BB0, 1'b0}, nf,
                '{1'b0, 1'b1, 16'h0101, 16'h0BB0, 16'h0003, 3'd2, 8'h66}};
    // Load to r5 with rs=5 unused: no stall, value still forwarded; r0 forwards like any register.
    tbl[6]  = '{1'b0, 1'b1, 1'b0,
                '{1'b1, 3'd5, 3'd0, 1'b0, 1'b1, 3'd1, 16'h0004, 8'h44, 16'h5050, 16'h0F0F},
                '{1'b1, 3'd5, 16'h7777, 1'b1}, '{1'b1, 3'd0, 16'h00C0, 1'b0}, nf,
                '{1'b0, 1'b1, 16'h7777, 16'h00C0, 16'h0004, 3'd1, 8'h44}};
    // Load-use on rs: stall with bubble, then the load result arrives from MEM.
    tbl[7]  = '{1'b0, 1'b1, 1'b0,
                '{1'b1, 3'd5, 3'd1, 1'b1, 1'b1, 3'd3, 16'h0005, 8'h33, 16'h0000, 16'h0001},
                '{1'b1, 3'd5, 16'h9999, 1'b1}, nf, nf,
                '{1'b1, 1'b0, 16'h7777, 16'h00C0, 16'h0004, 3'd1, 8'h44}};
    tbl[8]  = '{1'b0, 1'b1, 1'b0,
                '{1'b1, 3'd5, 3'd1, 1'b1, 1'b1, 3'd3, 16'h0005, 8'h33, 16'h0000, 16'h0001},
                nf, '{1'b1, 3'd5, 16'h5555, 1'b0}, nf,
                '{1'b0, 1'b1, 16'h5555, 16'h0001, 16'h0005, 3'd3, 8'h33}};
    // WB writes r1 in the same cycle rs=1 is read.
    tbl[9]  = '{1'b0, 1'b1, 1'b0,
                '{1'b1, 3'd1, 3'd2, 1'b1, 1'b0, 3'd5, 16'h0006, 8'h55, 16'h0000, 16'h0002},
                nf, nf, '{1'b1, 3'd1, 16'hBEEF, 1'b0},
`ifdef RF_WB_BYPASS_EN
                '{1'b0, 1'b1, 16'hBEEF, 16'h0002, 16'h0006, 3'd5, 8'h55}};
`else
                '{1'b1, 1'b0, 16'h5555, 16'h0001, 16'h0005, 3'd3, 8'h33}};
`endif
    // Next cycle the RF holds the new value either way.
    tbl[10] = '{1'b0, 1'b1, 1'b0,
                '{1'b1, 3'd1, 3'd2, 1'b1, 1'b0, 3'd5, 16'h0006, 8'h55, 16'hBEEF, 16'h0002},
                nf, nf, nf,
                '{1'b0, 1'b1, 16'hBEEF, 16'h0002, 16'h0006, 3'd5, 8'h55}};
    // id_valid=0 never raises a hazard even with a matching load in EX.
    tbl[11] = '{1'b0, 1'b1, 1'b0,
                '{1'b0, 3'd5, 3'd5, 1'b1, 1'b1, 3'd2, 16'h0007, 8'h77, 16'h1111, 16'h2222},
                '{1'b1, 3'd5, 16'h4444, 1'b1}, nf, nf,
                '{1'b0, 1'b0, 16'h4444, 16'h4444, 16'h0007, 3'd2, 8'h77}};

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Backpressure sequence: capture, freeze for 3 cycles (flush and load-use inside), release with flush.
    id_hold  = '{1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 3'd6, 16'h0008, 8'h88, 16'h0A0A, 16'h0B0B};
    id_new   = '{1'b1, 3'd4, 3'd5, 1'b1, 1'b1, 3'd7, 16'h0009, 8'h99, 16'h0C0C, 16'h0D0D};
    e_frozen = '{1'b1, 1'b1, 16'h0A0A, 16'h0B0B, 16'h0008, 3'd6, 8'h88};

    h = '{1'b0, 1'b1, 1'b0, id_hold, nf, nf, nf, '{1'b0, 1'b1, 16'h0A0A, 16'h0B0B, 16'h0008, 3'd6, 8'h88}};
    apply(h, "bp_capture");
    for (int c = 0; c < 3; c++) begin
      h = '{1'b0, 1'b0, (c == 1), id_new, nf, nf, nf, e_frozen};
      if (c == 2) h.ex = '{1'b1, 3'd5, 16'h0000, 1'b1};
      apply(h, $sformatf("bp_hold%0d", c));
    end
    h = '{1'b0, 1'b1, 1'b1, id_new, '{1'b1, 3'd5, 16'h3333, 1'b1}, nf, nf,
          '{1'b0, 1'b0, 16'h0A0A, 16'h0B0B, 16'h0008, 3'd6, 8'h88}};
    apply(h, "bp_release_flush");
    h = '{1'b0, 1'b1, 1'b0, id_new, nf, nf, nf, '{1'b0, 1'b1, 16'h0C0C, 16'h0D0D, 16'h0009, 3'd7, 8'h99}};
    apply(h, "after_flush");

    // Reset mid-stream wins over a simultaneous flush.
    h = '{1'b1, 1'b1, 1'b1, id_new, nf, nf, nf, '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 8'h00}};
    apply(h, "rst_over_flush");
    h = '{1'b0, 1'b1, 1'b0, id0, nf, nf, nf, '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 8'h00}};
    apply(h, "idle_after_rst");

    if (sb.size() != 0) chk("scoreboard_leftover", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
